// File: rtl/keypad_pkg.sv
// keypad_pkg: shared keypad dimensions, key code width and scanner states
package keypad_pkg;
  localparam int N_ROWS = 4;
  localparam int N_COLS = 4;
  localparam int KEY_W  = 4;
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;
endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: free-running divider producing a one-cycle sample tick every SCAN_DIV clocks
module scan_tick_gen #(
  parameter int SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(SCAN_DIV - 1);
  // count 0..SCAN_DIV-1 and wrap
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with debounced press/release and one-shot key_valid
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       row_in,
  output logic [3:0]       col_out,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);
  localparam int AW = $clog2(DEBOUNCE_SCANS + 1);
  logic [N_ROWS-1:0] row_s1, row_s2;
  logic              tick;
  state_t            state;
  logic [1:0]        col_idx, cand_row, low_row;
  logic [AW-1:0]     agree, agree_inc;
  logic              any_low, cand_low, agree_done;
  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (.clk(clk), .reset(reset), .tick(tick));
  assign any_low    = ~&row_s2;
  assign low_row    = !row_s2[0] ? 2'd0 : !row_s2[1] ? 2'd1 : !row_s2[2] ? 2'd2 : 2'd3;
  assign cand_low   = !row_s2[cand_row];
  assign agree_inc  = agree == AW'(DEBOUNCE_SCANS) ? agree : agree + 1'b1;
  assign agree_done = agree_inc == AW'(DEBOUNCE_SCANS);
  assign col_out    = ~(4'b0001 << col_idx);
  // two-flop synchronizer for the asynchronous rows
  always_ff @(posedge clk)
    if (reset) {row_s2, row_s1} <= '1;
    else {row_s2, row_s1} <= {row_s1, row_in};
  // scan / debounce / hold / release state machine, acting only on sample ticks
  always_ff @(posedge clk)
    if (reset) begin
      state     <= SCAN;
      col_idx   <= '0;
      cand_row  <= '0;
      agree     <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick)
        case (state)
          SCAN:
            if (any_low) begin
              cand_row <= low_row;
              agree    <= '0;
              state    <= DEBOUNCE;
            end else col_idx <= col_idx + 1'b1;
          DEBOUNCE:
            if (!cand_low) begin
              state   <= SCAN;
              col_idx <= col_idx + 1'b1;
            end else begin
              agree <= agree_inc;
              if (agree_done) begin
                key_code  <= {cand_row, col_idx};
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= PRESSED;
              end
            end
          PRESSED:
            if (!cand_low) begin
              agree <= '0;
              state <= RELEASE;
            end
          RELEASE:
            if (cand_low) state <= PRESSED;
            else begin
              agree <= agree_inc;
              if (agree_done) begin
                key_held <= 1'b0;
                state    <= SCAN;
                col_idx  <= col_idx + 1'b1;
              end
            end
          default: state <= SCAN;
        endcase
    end
endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles per sample tick (1 kHz at 100 MHz).
REQ-002 SHALL have parameter DEBOUNCE_SCANS, default 4, consecutive agreeing samples needed to accept a press or a release.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port row_in  input  4  asynchronous keypad rows, active-low (pulled up).
REQ-006 SHALL have port col_out  output  4  column strobe, one-cold active-low.
REQ-007 SHALL have port key_code  output  4  accepted key, row*4+col.
REQ-008 SHALL have port key_valid  output  1  single-cycle pulse when key_code updates.
REQ-009 SHALL have port key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 SHALL pass row_in through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-011 SHALL generate a sample tick once every SCAN_DIV cycles from a free-running counter that wraps from SCAN_DIV-1 to 0.
REQ-012 SHALL implement states SCAN, DEBOUNCE, PRESSED, RELEASE.
REQ-013 SCAN: on each tick with no row low, SHALL advance col_out to the next column (0->1->2->3->0).
REQ-014 SCAN: on a tick with any row low, SHALL latch candidate {row,col}, hold col_out, clear the agree count, and enter DEBOUNCE.
REQ-015 Multiple rows low SHALL select the lowest-index row; only one column is ever driven.
REQ-016 DEBOUNCE: each tick with the candidate row low SHALL increment the agree count; reaching DEBOUNCE_SCANS SHALL load key_code, pulse key_valid for exactly one cycle, set key_held, and enter PRESSED.
REQ-017 DEBOUNCE: any tick with the candidate row high SHALL return to SCAN and advance to the next column, with no key_valid.
REQ-018 PRESSED: col_out SHALL hold; a tick with the candidate row high SHALL clear the agree count and enter RELEASE; no further key_valid while held.
REQ-019 RELEASE: DEBOUNCE_SCANS consecutive ticks with the row high SHALL clear key_held and enter SCAN at the next column; a tick with the row low SHALL return to PRESSED without a new pulse.
REQ-020 key_code SHALL hold its last accepted value until the next accepted press.
REQ-021 Other keys pressed while in DEBOUNCE/PRESSED/RELEASE SHALL be ignored.
REQ-022 The agree count SHALL saturate and never wrap.

Reset
REQ-023 On reset: state SCAN, col_out 4'b1110, key_code 0, key_valid 0, key_held 0, synchronizer 4'b1111, tick and agree counters 0.
REQ-024 Reset asserted mid-operation SHALL take effect on the next clk edge and suppress any pending key_valid.

Structure
REQ-025 Package keypad_pkg SHALL hold the state enum, N_ROWS=4, N_COLS=4, and the key_code width.
REQ-026 Sub-module scan_tick_gen (parameter SCAN_DIV, outputs a one-cycle tick) SHALL provide the sample tick; everything else SHALL be in keypad_scanner.

Verification (SCAN_DIV=4, DEBOUNCE_SCANS=3)
REQ-027 Steady press, row 2 / col 1 -> key_code 4'h9, exactly one key_valid, key_held high until release is debounced.
REQ-028 Bounce: row low for 1 tick then high -> no key_valid; scanning resumes at the next column.
REQ-029 Rows 1 and 2 both low in col 3 -> key_code 4'h7.
REQ-030 Key held for 100 ticks -> exactly one key_valid; release-and-repress of the same key -> second pulse.
REQ-031 Reset asserted in PRESSED -> next cycle col_out 4'b1110, key_held 0, key_valid 0, key_code 0.
REQ-032 Release glitch (row high 1 tick, then low) in PRESSED -> key_held stays 1, no new key_valid.
